md_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide controller in the execute stage, beside the ALU.

---
 rtl/md_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_md_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// The multiplier is a 1-bit/cycle shift-add unit and the divider is a restoring divider.
module md_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flushE,
  output logic            stallE,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Operand decode, only used while sampling in StIdle
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_div, div_zero, div_ovf;

  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    sign_a   = a_signed & srcA[XLEN-1];
    sign_b   = b_signed & srcB[XLEN-1];
    mag_a    = sign_a ? -srcA : srcA;
    mag_b    = sign_b ? -srcB : srcB;
    is_div   = funct3[2];
    div_zero = (srcB == '0);
    // DIV and REM (funct3 bit 0 clear) are the signed divides that can overflow
    div_ovf  = ~funct3[0] & (srcA == MinInt) & (&srcB);
  end

  // Multiply step: prod_q = {partial sum, remaining multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_prod_s;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : {XLEN{1'b0}})};
    mul_next   = {mul_sum, prod_q[XLEN-1:1]};
    mul_prod_s = neg_q ? -mul_next : mul_next;
    mul_res    = (op_q == 3'd0) ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];
  end

  // Divide step: prod_q = {remainder, dividend/quotient}
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rem, div_res;

  always_comb begin
    div_shift = prod_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), prod_q[XLEN-2:0], div_ok};
    quo       = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    div_res   = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
  end

  logic last;
  assign last = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d   = funct3;
          neg_d  = sign_a ^ sign_b;
          rneg_d = sign_a;
          cnt_d  = '0;
          if (!is_div) begin
            state_d = StMul;
            opnd_d  = mag_a;
            prod_d  = {{XLEN{1'b0}}, mag_b};
          end else if (div_zero) begin
            state_d  = StDone;
            result_d = funct3[1] ? srcA : {XLEN{1'b1}};
          end else if (div_ovf) begin
            state_d  = StDone;
            result_d = funct3[1] ? {XLEN{1'b0}} : MinInt;
          end else begin
            state_d = StDiv;
            opnd_d  = mag_b;
            prod_d  = {{XLEN{1'b0}}, mag_a};
          end
        end
      end
      StMul: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          state_d  = StDone;
          result_d = mul_res;
        end
      end
      StDiv: begin
        prod_d = div_next;
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          state_d  = StDone;
          result_d = div_res;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A flushed op must leave no trace in the architectural outputs
    if (flushE) begin
      state_d  = StIdle;
      result_d = result_q;
    end

    busy_d = (state_d == StMul) || (state_d == StDiv);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign stallE = start & ~done_q & ~flushE;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: latency, stall, special cases, flush, reset.
module tb_md_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flushE;
  logic        stallE;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  md_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .srcA   (srcA),
    .srcB   (srcB),
    .flushE (flushE),
    .stallE (stallE),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one op just after a rising edge; that edge's following cycle is cycle 0.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          cyc;
    int          stalls;
    bit          seen;
    logic [31:0] got;
    cyc    = 0;
    stalls = 0;
    seen   = 1'b0;
    got    = 'x;
    start  = 1'b1;
    funct3 = f3;
    srcA   = a;
    srcB   = b;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (cyc == 0) check({tag, " busy@0"}, 32'(busy), 32'd0);
      if (stallE) stalls++;
      if (done) begin
        seen = 1'b1;
        got  = result;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " result"}, got, exp);
    check({tag, " stalls"}, 32'(stalls), 32'(lat));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          ndone;
    int          d1;
    int          d2;
    logic [31:0] r1;
    logic [31:0] r2;
    bit          early_done;

    rst    = 1'b0;
    start  = 1'b0;
    funct3 = 3'd0;
    srcA   = '0;
    srcB   = '0;
    flushE = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset stallE", 32'(stallE), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op("MUL 7*-3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("DIV -20/3", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("REM -20/3", 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIVU x/0", 3'd5, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REMU 9/0", 3'd7, 32'd9, 32'd0, 32'd9, 1);

    // Flush a DIV at cycle 10, then start a MUL right away
    start      = 1'b1;
    funct3     = 3'd4;
    srcA       = 32'hFFFF_FFEC;
    srcB       = 32'd3;
    early_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) early_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush no early done", 32'(early_done), 32'd0);
    flushE = 1'b1;
    @(negedge clk);
    check("flush stallE", 32'(stallE), 32'd0);
    check("flush busy before", 32'(busy), 32'd1);
    check("flush done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    flushE = 1'b0;
    check("flush busy after", 32'(busy), 32'd0);
    check("flush done after", 32'(done), 32'd0);
    check("flush result kept", result, 32'd9);
    run_op("MUL 5*6 after flush", 3'd0, 32'd5, 32'd6, 32'd30, 33);

    // Asynchronous reset in the middle of a MUL
    start  = 1'b1;
    funct3 = 3'd0;
    srcA   = 32'd7;
    srcB   = 32'hFFFF_FFFD;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst result", result, 32'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back MUL then DIV with start held high throughout
    start  = 1'b1;
    funct3 = 3'd0;
    srcA   = 32'd5;
    srcB   = 32'd6;
    ndone  = 0;
    d1     = -1;
    d2     = -1;
    r1     = '0;
    r2     = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          d1 = c;
          r1 = result;
        end else begin
          d2 = c;
          r2 = result;
        end
      end
      @(posedge clk);
      #1;
      if (ndone == 1 && c == d1) begin
        funct3 = 3'd5;
        srcA   = 32'd100;
        srcB   = 32'd7;
      end
    end
    start = 1'b0;
    check("b2b done count", 32'(ndone), 32'd2);
    check("b2b first done cycle", 32'(d1), 32'd33);
    check("b2b done spacing", 32'(d2 - d1), 32'd34);
    check("b2b MUL result", r1, 32'd30);
    check("b2b DIVU result", r2, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
